control_unit: RTL

Hardwired control sequencer that drives the bus-based CPU datapath. It steps through fetch, decode and execute micro-steps and asserts, each cycle, the register-in/out strobes, bus-source selects, ALU opcode and memory handshake the datapath consumes. It reads the instruction back from the datapath IR and sits between the datapath and the memory model at CPU top level.

---
 rtl/cpu_ctrl_pkg.sv | 96 +++++++++
 rtl/reg_sel_decoder.sv | 19 +
 rtl/control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the hardwired control sequencer:
//   - opcode constants (OP_ADD .. OP_HALT) and the ALU increment code
//   - bit positions of the IR fields (opcode, Ra, Rb, Rc)
//   - the sequencer state enum (IDLE, T0-T3 fetch, E0-E4 execute, HALT)
//   - an instruction-class enum plus helpers that map opcodes to classes
//     and immediate opcodes to their ALU operation.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_SHRA = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_ADDI = 5'h09;
  localparam logic [4:0] OP_ANDI = 5'h0A;
  localparam logic [4:0] OP_ORI  = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0C;
  localparam logic [4:0] OP_DIV  = 5'h0D;
  localparam logic [4:0] OP_NEG  = 5'h0E;
  localparam logic [4:0] OP_NOT  = 5'h0F;
  localparam logic [4:0] OP_LD   = 5'h10;
  localparam logic [4:0] OP_ST   = 5'h11;
  localparam logic [4:0] OP_MFHI = 5'h12;
  localparam logic [4:0] OP_MFLO = 5'h13;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [4:0] ALU_INC = 5'h1F;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  typedef enum logic [4:0] {
    IDLE = 5'd0,
    T0   = 5'd1,
    T1   = 5'd2,
    T2   = 5'd3,
    T3   = 5'd4,
    E0   = 5'd5,
    E1   = 5'd6,
    E2   = 5'd7,
    E3   = 5'd8,
    E4   = 5'd9,
    HALT = 5'd10
  } cu_state_t;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_IMM,
    CL_MULDIV,
    CL_UNARY,
    CL_LD,
    CL_ST,
    CL_MOVE,
    CL_NOP,
    CL_HALT,
    CL_ILL
  } instr_class_t;

  function automatic instr_class_t classify(input logic [4:0] op);
    if (op <= OP_ROL)      return CL_ALU;
    else if (op <= OP_ORI) return CL_IMM;
    else if (op <= OP_DIV) return CL_MULDIV;
    else if (op <= OP_NOT) return CL_UNARY;
    else begin
      case (op)
        OP_LD:            return CL_LD;
        OP_ST:            return CL_ST;
        OP_MFHI, OP_MFLO: return CL_MOVE;
        OP_NOP:           return CL_NOP;
        OP_HALT:          return CL_HALT;
        default:          return CL_ILL;
      endcase
    end
  endfunction

  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder
//   Converts a 4-bit register index plus enable into a one-hot select
//   for the sixteen general registers. All zeros when disabled.
// Ports:
//   idx    in  4   register index
//   en     in  1   select enable
//   onehot out 16  one-hot register select
module reg_sel_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Hardwired control sequencer for the bus-based CPU datapath. Steps
//   through fetch (T0-T3) and execute (E0-E4) micro-steps and drives the
//   datapath strobes, ALU opcode and memory handshake for each cycle.
//
//   Optional feature: define CU_MEM_TIMEOUT_EN to add a memory wait
//   timeout (parameter MEM_TIMEOUT, default 255). Without it, memory
//   waits are unbounded and err is set only by an illegal opcode.
//
// Ports:
//   clk, clear          clock, synchronous active-high reset
//   start               one-cycle pulse, leaves IDLE
//   ir[31:0]            datapath IR contents
//   mem_ack             memory completion pulse
//   PCout..Cout         bus-source strobes (at most one source per cycle)
//   reg_out, reg_in     one-hot register out / load strobes
//   MAR_enable..ZLow_enable  register load enables, mdr_read = memory into MDR
//   alu_op              ALU opcode
//   mem_rd, mem_wr      memory request levels, held until mem_ack
//   run                 high outside IDLE/HALT
//   err                 sticky error flag
//   state_dbg           current state encoding
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, PC+1 into Z
// T1    | Z into PC
// T2    | instruction read, wait for mem_ack
// T3    | MDR into IR
// E0-E4 | execute steps, meaning depends on instruction class
// HALT  | stopped until clear
module control_unit
  import cpu_ctrl_pkg::*;
`ifdef CU_MEM_TIMEOUT_EN
#(
  parameter int MEM_TIMEOUT = 255
)
`endif
(
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ack,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        MAR_enable,
  output logic        PC_enable,
  output logic        IR_enable,
  output logic        Yin,
  output logic        MDRin,
  output logic        mdr_read,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHigh_enable,
  output logic        ZLow_enable,
  output logic [4:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        run,
  output logic        err,
  output logic [4:0]  state_dbg
);

  cu_state_t    state;
  instr_class_t cls;
  logic [4:0]   opc;
  logic [3:0]   ra, rb, rc;
  logic         rd_wait, wr_wait;
  logic [3:0]   rout_idx, rin_idx;
  logic         rout_en, rin_en;

  // The datapath IR is stable from T3 until the next T3, so execute steps
  // decode it directly. The C field goes straight to the datapath.
  assign opc = ir[IR_OP_HI:IR_OP_LO];
  assign ra  = ir[IR_RA_HI:IR_RA_LO];
  assign rb  = ir[IR_RB_HI:IR_RB_LO];
  assign rc  = ir[IR_RC_HI:IR_RC_LO];
  assign cls = classify(opc);

  logic unused_c_bits;
  assign unused_c_bits = ^ir[14:0];

  assign rd_wait = (state == T2) || (state == E3 && cls == CL_LD);
  assign wr_wait = (state == E4 && cls == CL_ST);

`ifdef CU_MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      err   <= 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
      tmo_cnt <= 8'(MEM_TIMEOUT - 1);
`endif
    end else begin
      case (state)
        IDLE: if (start) state <= T0;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   if (mem_ack) state <= T3;
        T3:   state <= E0;
        E0: begin
          case (cls)
            CL_NOP, CL_MOVE: state <= T0;
            CL_HALT:         state <= HALT;
            CL_ILL: begin
              state <= HALT;
              err   <= 1'b1;
            end
            default:         state <= E1;
          endcase
        end
        E1: state <= (cls == CL_UNARY) ? T0 : E2;
        E2: state <= (cls == CL_ALU || cls == CL_IMM) ? T0 : E3;
        E3: begin
          if (cls == CL_MULDIV)                 state <= T0;
          else if (cls == CL_ST)                state <= E4;
          else if (mem_ack)                     state <= E4;
        end
        E4: begin
          if (cls == CL_LD || mem_ack) state <= T0;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
`ifdef CU_MEM_TIMEOUT_EN
      // Down-counter reloads whenever no wait is in progress, so every
      // wait state starts with a full budget. Terminal count aborts.
      if ((rd_wait || wr_wait) && !mem_ack) begin
        if (tmo_cnt == 8'd0) begin
          state <= HALT;
          err   <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - 8'd1;
        end
      end else begin
        tmo_cnt <= 8'(MEM_TIMEOUT - 1);
      end
`endif
    end
  end

  always_comb begin
    PCout        = 1'b0;
    ZHighout     = 1'b0;
    ZLowout      = 1'b0;
    HIout        = 1'b0;
    LOout        = 1'b0;
    MDRout       = 1'b0;
    Cout         = 1'b0;
    MAR_enable   = 1'b0;
    PC_enable    = 1'b0;
    IR_enable    = 1'b0;
    Yin          = 1'b0;
    MDRin        = 1'b0;
    mdr_read     = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    ZHigh_enable = 1'b0;
    ZLow_enable  = 1'b0;
    alu_op       = 5'd0;
    rout_en      = 1'b0;
    rout_idx     = 4'd0;
    rin_en       = 1'b0;
    rin_idx      = 4'd0;
    case (state)
      T0: begin
        PCout       = 1'b1;
        MAR_enable  = 1'b1;
        alu_op      = ALU_INC;
        ZLow_enable = 1'b1;
      end
      T1: begin
        ZLowout   = 1'b1;
        PC_enable = 1'b1;
      end
      T2: begin
        // MDR captures memory data in the ack cycle itself.
        MDRin    = mem_ack;
        mdr_read = mem_ack;
      end
      T3: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      E0: begin
        case (cls)
          CL_ALU, CL_IMM, CL_LD, CL_ST: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            Yin      = 1'b1;
          end
          CL_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = ra;
            Yin      = 1'b1;
          end
          CL_UNARY: begin
            rout_en     = 1'b1;
            rout_idx    = rb;
            alu_op      = opc;
            ZLow_enable = 1'b1;
          end
          CL_MOVE: begin
            HIout   = (opc == OP_MFHI);
            LOout   = (opc != OP_MFHI);
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          default: ;
        endcase
      end
      E1: begin
        case (cls)
          CL_ALU: begin
            rout_en     = 1'b1;
            rout_idx    = rc;
            alu_op      = opc;
            ZLow_enable = 1'b1;
          end
          CL_IMM: begin
            Cout        = 1'b1;
            alu_op      = imm_alu_op(opc);
            ZLow_enable = 1'b1;
          end
          CL_MULDIV: begin
            rout_en      = 1'b1;
            rout_idx     = rb;
            alu_op       = opc;
            ZHigh_enable = 1'b1;
            ZLow_enable  = 1'b1;
          end
          CL_UNARY: begin
            ZLowout = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          CL_LD, CL_ST: begin
            Cout        = 1'b1;
            alu_op      = OP_ADD;
            ZLow_enable = 1'b1;
          end
          default: ;
        endcase
      end
      E2: begin
        case (cls)
          CL_ALU, CL_IMM: begin
            ZLowout = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          CL_MULDIV: begin
            ZLowout = 1'b1;
            LOin    = 1'b1;
          end
          CL_LD, CL_ST: begin
            ZLowout    = 1'b1;
            MAR_enable = 1'b1;
          end
          default: ;
        endcase
      end
      E3: begin
        case (cls)
          CL_MULDIV: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
          end
          CL_LD: begin
            MDRin    = mem_ack;
            mdr_read = mem_ack;
          end
          CL_ST: begin
            rout_en  = 1'b1;
            rout_idx = ra;
            MDRin    = 1'b1;
          end
          default: ;
        endcase
      end
      E4: begin
        if (cls == CL_LD) begin
          MDRout  = 1'b1;
          rin_en  = 1'b1;
          rin_idx = ra;
        end
      end
      default: ;
    endcase
  end

  // Requests drop in the clear cycle so memory never sees a stale request.
  assign mem_rd    = rd_wait && !clear;
  assign mem_wr    = wr_wait && !clear;
  assign run       = (state != IDLE) && (state != HALT);
  assign state_dbg = state;

  reg_sel_decoder u_out_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (reg_out)
  );

  reg_sel_decoder u_in_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (reg_in)
  );

endmodule
